// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster constants and helpers for the timing generator and renderer.
package vga_pkg;

  localparam int unsigned CRD_W = 10;

  localparam int unsigned VGA_CLK_DIV   = 2;
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  // Half-open interval test lo <= v < hi on a coordinate.
  function automatic logic in_range(input logic [CRD_W-1:0] v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_mod_counter.sv
// Wrap-around counter with enable; exposes its next value and a wrap strobe for chaining.
module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS   = VGA_H_TOTAL,
  parameter int unsigned RESET_VAL = MODULUS - 1,
  parameter int unsigned W         = CRD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_c_o,
  output logic         wrap_c_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_c_o = en_i && (cnt_q == W'(MODULUS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_c_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= W'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign nxt_c_o = cnt_d;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, chained h/v counters, registered blanking/sync/frame strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV         = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE       = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT         = VGA_H_FRONT,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BACK          = VGA_H_BACK,
  parameter int unsigned V_VISIBLE       = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT         = VGA_V_FRONT,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BACK          = VGA_V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pixel_tick,
  output logic [CRD_W-1:0] x_crd,
  output logic [CRD_W-1:0] y_crd,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_tick
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic SYNC_ON = !SYNC_ACTIVE_LOW;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CRD_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  // Decoded straight from the divider register so counters see it on the same edge.
  assign pixel_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = pixel_tick ? '0 : div_q + 1'b1;
  end

  mod_counter #(.MODULUS(H_TOTAL), .W(CRD_W)) u_h_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (pixel_tick),
    .cnt_o    (x_crd),
    .nxt_c_o  (h_nxt),
    .wrap_c_o (h_wrap)
  );

  mod_counter #(.MODULUS(V_TOTAL), .W(CRD_W)) u_v_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (h_wrap),
    .cnt_o    (y_crd),
    .nxt_c_o  (v_nxt),
    .wrap_c_o (v_wrap)
  );

  // Decode from next-state counts so the registered flags line up with x_crd/y_crd.
  always_comb begin
    video_on_d   = (32'(h_nxt) < H_VISIBLE) && (32'(v_nxt) < V_VISIBLE);
    hsync_d      = in_range(h_nxt, HS_START, HS_END) ? SYNC_ON : !SYNC_ON;
    vsync_d      = in_range(v_nxt, VS_START, VS_END) ? SYNC_ON : !SYNC_ON;
    frame_tick_d = v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      video_on_q   <= 1'b0;
      hsync_q      <= !SYNC_ON;
      vsync_q      <= !SYNC_ON;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size build plus two shrunken rasters checked every clk against a closed-form model.
module tb_vga_timing;

  localparam int unsigned S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int unsigned S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 1;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pt  [3];
  logic [9:0] x   [3];
  logic [9:0] y   [3];
  logic       von [3];
  logic       hs  [3];
  logic       vs  [3];
  logic       ft  [3];

  int   errors = 0;
  int   checks = 0;
  int   n      = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  vga_timing dut0 (
    .clk(clk), .rst(rst), .pixel_tick(pt[0]), .x_crd(x[0]), .y_crd(y[0]),
    .video_on(von[0]), .hsync(hs[0]), .vsync(vs[0]), .frame_tick(ft[0])
  );

  vga_timing #(
    .CLK_DIV(2), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .pixel_tick(pt[1]), .x_crd(x[1]), .y_crd(y[1]),
    .video_on(von[1]), .hsync(hs[1]), .vsync(vs[1]), .frame_tick(ft[1])
  );

  vga_timing #(
    .CLK_DIV(1), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE_LOW(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .pixel_tick(pt[2]), .x_crd(x[2]), .y_crd(y[2]),
    .video_on(von[2]), .hsync(hs[2]), .vsync(vs[2]), .frame_tick(ft[2])
  );

  // Expected outputs after n clk edges since reset release, from raster arithmetic alone.
  function automatic obs_t model(input int cyc, input int idx);
    obs_t m;
    int d, hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, ticks, lin, xx, yy;
    bit sal;
    if (idx == 0) begin
      d = 2; hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33; sal = 1'b1;
    end else begin
      d = (idx == 1) ? 2 : 1;
      hv = 16; hf = 2; hsw = 3; hb = 2; vv = 6; vf = 1; vsw = 2; vb = 1;
      sal = (idx == 1);
    end
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    ticks = cyc / d;
    lin   = (ticks == 0) ? ht * vt - 1 : (ticks - 1) % (ht * vt);
    xx    = lin % ht;
    yy    = lin / ht;
    m.pt  = ((cyc % d) == d - 1);
    m.x   = 10'(xx);
    m.y   = 10'(yy);
    m.von = (xx < hv) && (yy < vv);
    m.hs  = ((xx >= hv + hf) && (xx < hv + hf + hsw)) ? !sal : sal;
    m.vs  = ((yy >= vv + vf) && (yy < vv + vf + vsw)) ? !sal : sal;
    m.ft  = (ticks > 0) && ((cyc % d) == 0) && (lin == 0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Push the model's prediction for every build on each edge.
  always @(posedge clk) begin
    if (rst) n = 0;
    else     n = n + 1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(n, i));
  end

  // Pop and compare mid-cycle, away from the active edge.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        chk($sformatf("d%0d.pixel_tick n=%0d", i, n), 32'(pt[i]),  32'(e.pt));
        chk($sformatf("d%0d.x_crd n=%0d", i, n),      32'(x[i]),   32'(e.x));
        chk($sformatf("d%0d.y_crd n=%0d", i, n),      32'(y[i]),   32'(e.y));
        chk($sformatf("d%0d.video_on n=%0d", i, n),   32'(von[i]), 32'(e.von));
        chk($sformatf("d%0d.hsync n=%0d", i, n),      32'(hs[i]),  32'(e.hs));
        chk($sformatf("d%0d.vsync n=%0d", i, n),      32'(vs[i]),  32'(e.vs));
        chk($sformatf("d%0d.frame_tick n=%0d", i, n), 32'(ft[i]), 32'(e.ft));
      end
    end
  end

  initial begin
    obs_t m;
    int   g;

    // Power-on reset held across several clocks.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.x",          32'(x[0]),   32'd799);
    chk("rst.y",          32'(y[0]),   32'd524);
    chk("rst.video_on",   32'(von[0]), 32'd0);
    chk("rst.hsync",      32'(hs[0]),  32'd1);
    chk("rst.vsync",      32'(vs[0]),  32'd1);
    chk("rst.frame_tick", 32'(ft[0]),  32'd0);
    chk("rst.pixel_tick", 32'(pt[0]),  32'd0);
    chk("rst.div1_tick",  32'(pt[2]),  32'd1);
    chk("rst.idle_hi",    32'(hs[2]),  32'd0);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rel1.pixel_tick", 32'(pt[0]), 32'd1);
    chk("rel1.frame_tick", 32'(ft[0]), 32'd0);
    @(negedge clk);
    chk("rel2.frame_tick", 32'(ft[0]),  32'd1);
    chk("rel2.x",          32'(x[0]),   32'd0);
    chk("rel2.y",          32'(y[0]),   32'd0);
    chk("rel2.video_on",   32'(von[0]), 32'd1);

    // Two full-size lines plus many frames of the shrunken rasters.
    repeat (3400) @(negedge clk);

    // Land inside the small raster's vsync pulse, then reset asynchronously.
    g = 0;
    m = model(n, 1);
    while (!(m.y == 10'd7 && m.x == 10'd10) && g < 600) begin
      @(negedge clk);
      m = model(n, 1);
      g++;
    end
    chk("mid.reach_vsync", 32'(g < 600), 32'd1);
    chk("mid.vsync_active", 32'(vs[1]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid.async_vsync", 32'(vs[1]),  32'd1);
    chk("mid.async_x",     32'(x[1]),   32'd22);
    chk("mid.async_y",     32'(y[1]),   32'd9);
    chk("mid.async_x0",    32'(x[0]),   32'd799);
    chk("mid.async_y0",    32'(y[0]),   32'd524);
    chk("mid.async_von",   32'(von[0]), 32'd0);
    chk("mid.async_vs2",   32'(vs[2]),  32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    repeat (2) @(negedge clk);
    chk("mid.rel2.frame_tick0", 32'(ft[0]), 32'd1);
    chk("mid.rel2.frame_tick1", 32'(ft[1]), 32'd1);
    chk("mid.rel2.x1",          32'(x[1]),  32'd0);
    chk("mid.rel2.y1",          32'(y[1]),  32'd0);
    chk("mid.rel2.video_on1",   32'(von[1]), 32'd1);

    repeat (2000) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
